// File: rtl/plab4_net_router_input_ctrl_tdm_arb_if.sv
// Handshake bundle between the per-domain input queues, the TDM input
// controller and the output-port arbiters of one router input port.
interface plab4_net_router_input_ctrl_tdm_arb_if #(
   parameter int unsigned p_num_domains = 4,
   parameter int unsigned p_dest_nbits  = 3
);
   logic [p_num_domains*p_dest_nbits-1:0] dest;
   logic [p_num_domains-1:0]              in_val;
   logic [p_num_domains-1:0]              in_rdy;
   logic [2:0]                            reqs;
   logic [2:0]                            grants;

   modport master (output dest, in_val, grants, input in_rdy, reqs);
   modport slave  (input dest, in_val, grants, output in_rdy, reqs);
endinterface

// File: rtl/plab4_net_router_input_ctrl_tdm_arb.sv
// Router input control with a fixed time-division schedule across security
// domains; only the epoch owner may request, and a trailing dead window
// keeps transfers from spilling into the next domain's epoch.
module plab4_net_router_input_ctrl_tdm_arb #(
   parameter int unsigned p_router_id    = 0,
   parameter int unsigned p_num_routers  = 8,
   parameter int unsigned p_num_domains  = 4,
   parameter int unsigned p_epoch_len    = 8,
   parameter int unsigned p_dead_cycles  = 1,
   parameter logic [2:0]  p_default_reqs = 3'b001,
   localparam int unsigned c_dest_nbits  = $clog2(p_num_routers),
   localparam int unsigned c_dom_nbits   = $clog2(p_num_domains)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   plab4_net_router_input_ctrl_tdm_arb_if.slave io,
   output logic [c_dom_nbits-1:0] domain,
   output logic                   epoch_start,
   output logic                   dead
);

   localparam int unsigned c_ep_nbits = (p_epoch_len > 1) ? $clog2(p_epoch_len) : 1;
   localparam logic [c_ep_nbits-1:0]  c_ep_last    = c_ep_nbits'(p_epoch_len - 1);
   localparam logic [c_ep_nbits-1:0]  c_dead_start = c_ep_nbits'(p_epoch_len - p_dead_cycles);
   localparam logic [c_dom_nbits-1:0] c_dom_last   = c_dom_nbits'(p_num_domains - 1);

   if (p_num_domains < 2) begin : g_chk_dom
      $fatal(1, "p_num_domains must be >= 2");
   end
   if (p_epoch_len < 2) begin : g_chk_epoch
      $fatal(1, "p_epoch_len must be >= 2");
   end
   if (p_dead_cycles >= p_epoch_len) begin : g_chk_dead
      $fatal(1, "p_dead_cycles must be < p_epoch_len");
   end

   logic [c_ep_nbits-1:0]   epoch_cnt_q, epoch_cnt_d;
   logic [c_dom_nbits-1:0]  dom_cnt_q, dom_cnt_d;
   logic                    act_val;
   logic [c_dest_nbits-1:0] act_dest;
   logic [2:0]              route;
   logic                    fire;

   always_comb begin
      epoch_cnt_d = epoch_cnt_q + 1'b1;
      dom_cnt_d   = dom_cnt_q;
      if (epoch_cnt_q == c_ep_last) begin
         epoch_cnt_d = '0;
         dom_cnt_d   = (dom_cnt_q == c_dom_last) ? '0 : dom_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         epoch_cnt_q <= '0;
         dom_cnt_q   <= '0;
      end else begin
         epoch_cnt_q <= epoch_cnt_d;
         dom_cnt_q   <= dom_cnt_d;
      end
   end

   // With no dead cycles the start threshold would alias to 0 when
   // p_epoch_len is a power of two, so it is gated explicitly.
   always_comb begin
      domain      = dom_cnt_q;
      epoch_start = (epoch_cnt_q == '0);
      dead        = (p_dead_cycles != 0) && (epoch_cnt_q >= c_dead_start);
   end

   // Only the active domain's slice is ever selected, so idle or saturated
   // neighbours cannot influence reqs or in_rdy.
   always_comb begin
      act_val  = 1'b0;
      act_dest = '0;
      for (int unsigned k = 0; k < p_num_domains; k++) begin
         if (dom_cnt_q == c_dom_nbits'(k)) begin
            act_val  = io.in_val[k];
            act_dest = io.dest[k*c_dest_nbits +: c_dest_nbits];
         end
      end
      route     = (act_dest == c_dest_nbits'(p_router_id)) ? 3'b010 : p_default_reqs;
      io.reqs   = (act_val && !dead) ? route : 3'b000;
      fire      = act_val && !dead && (|(io.reqs & io.grants));
      io.in_rdy = '0;
      for (int unsigned k = 0; k < p_num_domains; k++) begin
         if (dom_cnt_q == c_dom_nbits'(k)) begin
            io.in_rdy[k] = fire;
         end
      end
   end

endmodule
